// File: rtl/dmem_wait_responder.sv
// Multi-cycle data-memory responder for the MA-stage data port: services each
// access after LATENCY cycles, stalls the pipeline via busy, flags misalignment.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [1:0]  mem_write,
  input  logic [1:0]  mem_read,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a request is any nonzero mem_write/mem_read; the pipeline holds
  // it stable while busy=1 and advances at the end of the busy=0 DONE cycle.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_data;
  logic [1:0]    cap_size;
  logic          cap_write;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic [AW+1:0] sel_addr;
  logic [31:0]   sel_data;
  logic [1:0]    sel_size;
  logic          sel_write;
  logic          sel_mis;
  logic [4:0]    sh;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   rd_val;
  logic [31:0]   resp_data;
  logic [31:0]   mask;
  logic [31:0]   wr_word;
  logic          unused_addr;

  assign unused_addr = ^address[31:AW+2];
  assign req         = (mem_write != 2'b00) || (mem_read != 2'b00);
  assign dbg_state   = state;
  assign busy        = reset && (((state == ST_IDLE) && req) || (state == ST_WAIT));

  // In IDLE the live bus is decoded; afterwards only the captured copy matters.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_addr  = address[AW+1:0];
      sel_data  = data_in;
      sel_write = (mem_write != 2'b00);
      sel_size  = (mem_write != 2'b00) ? mem_write : mem_read;
    end else begin
      sel_addr  = cap_addr;
      sel_data  = cap_data;
      sel_write = cap_write;
      sel_size  = cap_size;
    end
  end

  always_comb begin
    sel_mis = 1'b0;
    case (sel_size)
      2'b10:   sel_mis = sel_addr[0];
      2'b11:   sel_mis = (sel_addr[1:0] != 2'b00);
      default: sel_mis = 1'b0;
    endcase
  end

  assign sh      = {sel_addr[1:0], 3'b000};
  assign rd_word = mem[sel_addr[AW+1:2]];
  assign shifted = rd_word >> sh;

  always_comb begin
    rd_val = 32'h0;
    mask   = 32'h0;
    case (sel_size)
      2'b01: begin
        rd_val = {24'h0, shifted[7:0]};
        mask   = 32'h0000_00ff << sh;
      end
      2'b10: begin
        rd_val = {16'h0, shifted[15:0]};
        mask   = 32'h0000_ffff << sh;
      end
      2'b11: begin
        rd_val = rd_word;
        mask   = 32'hffff_ffff;
      end
      default: begin
        rd_val = 32'h0;
        mask   = 32'h0;
      end
    endcase
  end

  assign resp_data = (sel_write || sel_mis) ? 32'h0 : rd_val;
  assign wr_word   = (rd_word & ~mask) | ((sel_data << sh) & mask);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_data  <= 32'h0;
      cap_size  <= 2'b00;
      cap_write <= 1'b0;
      data_out  <= 32'h0;
      err       <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_out <= 32'h0;
          err      <= 1'b0;
          if (req) begin
            cap_addr  <= sel_addr;
            cap_data  <= sel_data;
            cap_size  <= sel_size;
            cap_write <= sel_write;
            cnt       <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state    <= ST_DONE;
              data_out <= resp_data;
              err      <= sel_mis;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state    <= ST_DONE;
            data_out <= resp_data;
            err      <= sel_mis;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          // Committing on the way out lets the very next access see the data.
          state    <= ST_IDLE;
          data_out <= 32'h0;
          err      <= 1'b0;
          if (sel_write && !sel_mis) mem[sel_addr[AW+1:2]] <= wr_word;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: main instance at LATENCY=2, plus
// LATENCY=1 and LATENCY=7 instances on the same bus for the back-to-back sweep.
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  mem_write;
  logic [1:0]  mem_read;

  logic [31:0] data_out, data_out1, data_out7;
  logic        busy, busy1, busy7;
  logic        err, err1, err7;
  logic [1:0]  st, st1, st7;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .mem_write(mem_write), .mem_read(mem_read), .data_out(data_out),
    .busy(busy), .err(err), .dbg_state(st));

  dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .mem_write(mem_write), .mem_read(mem_read), .data_out(data_out1),
    .busy(busy1), .err(err1), .dbg_state(st1));

  dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(7)) dut7 (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .mem_write(mem_write), .mem_read(mem_read), .data_out(data_out7),
    .busy(busy7), .err(err7), .dbg_state(st7));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    mem_write = 2'b00;
    mem_read  = 2'b00;
    address   = 32'h0;
    data_in   = 32'h0;
  endtask

  // One access on the LATENCY=2 instance, checked cycle by cycle from request
  // (cycle 0) through DONE (cycle 2) and the cycle after.
  task automatic access(input string tag, input logic [1:0] we, input logic [1:0] re,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    mem_write = we;
    mem_read  = re;
    address   = addr;
    data_in   = wdata;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk({tag, ".busy_wait"}, {31'h0, busy}, 32'h1);
      chk({tag, ".dout_pre"}, data_out, 32'h0);
      @(negedge clk);
      #1;
    end
    chk({tag, ".state_done"}, {30'h0, st}, {30'h0, S_DONE});
    chk({tag, ".busy_done"}, {31'h0, busy}, 32'h0);
    chk({tag, ".dout"}, data_out, exp_data);
    chk({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
    @(negedge clk);
    idle_bus();
    #1;
    chk({tag, ".dout_post"}, data_out, 32'h0);
    chk({tag, ".err_post"}, {31'h0, err}, 32'h0);
    chk({tag, ".busy_post"}, {31'h0, busy}, 32'h0);
  endtask

  int ret1, ret2, ret7, dbl, busy_low;
  logic p1, p2, p7;
  logic [31:0] got1, got2, got7;

  initial begin
    idle_bus();
    reset = 1'b0;
    mem_read = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.busy_forced", {31'h0, busy}, 32'h0);
    chk("reset.state", {30'h0, st}, {30'h0, S_IDLE});
    chk("reset.dout", data_out, 32'h0);
    chk("reset.err", {31'h0, err}, 32'h0);
    @(negedge clk);
    idle_bus();
    reset = 1'b1;
    #1;
    chk("idle.busy", {31'h0, busy}, 32'h0);

    access("wr_word",   2'b11, 2'b00, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    access("rd_word",   2'b00, 2'b11, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access("wr_byte",   2'b01, 2'b00, 32'h11,  32'h000000AA, 32'h0,        1'b0);
    access("rd_merged", 2'b00, 2'b11, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0);
    access("rd_half",   2'b00, 2'b10, 32'h12,  32'h0,        32'h0000DEAD, 1'b0);
    access("rd_byte",   2'b00, 2'b01, 32'h13,  32'h0,        32'h000000DE, 1'b0);
    access("wr_mis",    2'b11, 2'b00, 32'h13,  32'h12345678, 32'h0,        1'b1);
    access("rd_after",  2'b00, 2'b11, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0);
    access("rd_mis_h",  2'b00, 2'b10, 32'h11,  32'h0,        32'h0,        1'b1);
    access("wr_wrap",   2'b11, 2'b00, 32'h400, 32'hCAFEF00D, 32'h0,        1'b0);
    access("rd_wrap",   2'b00, 2'b11, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0);
    access("both",      2'b11, 2'b11, 32'h04,  32'h00000055, 32'h0,        1'b0);
    access("rd_both",   2'b00, 2'b11, 32'h04,  32'h0,        32'h00000055, 1'b0);
    access("wr_half",   2'b10, 2'b00, 32'h06,  32'h0000BEEF, 32'h0,        1'b0);
    access("rd_half_w", 2'b00, 2'b11, 32'h04,  32'h0,        32'hBEEF0055, 1'b0);

    // Reset during WAIT aborts the write and clears memory.
    @(negedge clk);
    mem_write = 2'b11;
    address   = 32'h20;
    data_in   = 32'h11111111;
    @(negedge clk);
    #1;
    chk("rst_mid.in_wait", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid.busy_low", {31'h0, busy}, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_mid.busy_next", {31'h0, busy}, 32'h0);
    chk("rst_mid.state", {30'h0, st}, {30'h0, S_IDLE});
    chk("rst_mid.dout", data_out, 32'h0);
    idle_bus();
    reset = 1'b1;
    access("rd_aborted", 2'b00, 2'b11, 32'h20, 32'h0, 32'h0,        1'b0);
    access("rd_cleared", 2'b00, 2'b11, 32'h10, 32'h0, 32'h0,        1'b0);

    // Back-to-back sweep: 24 cycles of continuous requests on all instances.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_write = 2'b11;
    address   = 32'h30;
    data_in   = 32'h0A0B0C0D;
    ret1 = 0; ret2 = 0; ret7 = 0; dbl = 0; busy_low = 0;
    p1 = 1'b0; p2 = 1'b0; p7 = 1'b0;
    #1;
    for (int c = 0; c < 24; c++) begin
      if (st1 == S_DONE) ret1++;
      if (st  == S_DONE) ret2++;
      if (st7 == S_DONE) ret7++;
      if ((p1 && st1 == S_DONE) || (p2 && st == S_DONE) || (p7 && st7 == S_DONE)) dbl++;
      if (!busy) busy_low++;
      p1 = (st1 == S_DONE);
      p2 = (st == S_DONE);
      p7 = (st7 == S_DONE);
      @(negedge clk);
      #1;
    end
    idle_bus();
    chk("sweep.l1_retires", ret1, 32'd12);
    chk("sweep.l2_retires", ret2, 32'd8);
    chk("sweep.l7_retires", ret7, 32'd3);
    chk("sweep.double_retire", dbl, 32'd0);
    chk("sweep.l2_busy_low", busy_low, 32'd8);
    chk("sweep.l7_idle_after", {30'h0, st7}, {30'h0, S_IDLE});

    @(negedge clk);
    mem_read = 2'b11;
    address  = 32'h30;
    got1 = 32'hFFFFFFFF; got2 = 32'hFFFFFFFF; got7 = 32'hFFFFFFFF;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (st1 == S_DONE && got1 == 32'hFFFFFFFF) got1 = data_out1;
      if (st  == S_DONE && got2 == 32'hFFFFFFFF) got2 = data_out;
      if (st7 == S_DONE && got7 == 32'hFFFFFFFF) got7 = data_out7;
      @(negedge clk);
      #1;
    end
    idle_bus();
    chk("sweep.l1_data", got1, 32'h0A0B0C0D);
    chk("sweep.l2_data", got2, 32'h0A0B0C0D);
    chk("sweep.l7_data", got7, 32'h0A0B0C0D);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
